// File: rtl/atom_soc_pkg.sv
// Shared definitions for the data-memory crossbar: FSM states, tick window
// geometry and the default slave address map.
package atom_soc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } xbar_state_e;

  // Tick counter occupies one 8-byte window: low word at +0, high word at +4.
  localparam int TICK_WIN_LSB = 3;

  localparam int                          DEF_NUM_SLAVES  = 4;
  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_BASE   = {32'h4000_0000, 32'h3000_0000,
                                                             32'h2000_0000, 32'h1000_0000};
  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_MASK   = {DEF_NUM_SLAVES{32'hF000_0000}};
  localparam logic [31:0]                 DEF_TICK_BASE   = 32'hFFFF_FF00;
  localparam logic [7:0]                  DEF_TIMEOUT_CYC = 8'd255;

endpackage

// File: rtl/atom_addr_decoder.sv
// Address decode for the crossbar: tick window first, then the lowest-index
// matching slave window, otherwise a miss.
module atom_addr_decoder
  import atom_soc_pkg::*;
#(
  parameter int                         NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE   = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK   = DEF_SLV_MASK,
  parameter logic [31:0]                TICK_BASE  = DEF_TICK_BASE
) (
  input  logic [31:0]           addr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  tick_hit_o,
  output logic                  miss_o
);

  logic [NUM_SLAVES-1:0] match;
  logic                  found;

  assign tick_hit_o = (addr_i[31:TICK_WIN_LSB] == TICK_BASE[31:TICK_WIN_LSB]);

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_match
    assign match[k] = ((addr_i & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]);
  end

  // Overlapping windows resolve to the lowest index; a tick hit suppresses all.
  always_comb begin
    hit_o = '0;
    found = tick_hit_o;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (match[k] && !found) begin
        hit_o[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign miss_o = !tick_hit_o && (match == '0);

endmodule

// File: rtl/atom_dmem_xbar.sv
// Single-master data-memory crossbar with per-slave handshake, response
// timeout and a built-in free-running 64-bit tick counter.
module atom_dmem_xbar
  import atom_soc_pkg::*;
#(
  parameter int                       NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE    = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK    = DEF_SLV_MASK,
  parameter logic [31:0]              TICK_BASE   = DEF_TICK_BASE,
  parameter logic [7:0]               TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     m_valid_i,
  output logic                     m_ready_o,
  input  logic [31:0]              m_addr_i,
  input  logic [31:0]              m_wdata_i,
  input  logic [2:0]               m_width_i,
  input  logic                     m_we_i,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic [31:0]              m_rdata_o,
  output logic [NUM_SLAVES-1:0]    s_valid_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  output logic [2:0]               s_width_o,
  output logic                     s_we_o,
  input  logic [NUM_SLAVES-1:0]    s_ready_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES*32-1:0] s_rdata_i
);

  xbar_state_e           state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d, dec_hit;
  logic                  dec_tick, dec_miss;
  logic [31:0]           addr_q, wdata_q, rdata_q, rdata_d, sel_rdata;
  logic [2:0]            width_q;
  logic                  we_q, err_q, err_d;
  logic [7:0]            to_q, to_d;
  logic [63:0]           tick_q, tick_d;
  logic                  accept, sel_ready, sel_ack, to_expire;

  atom_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .TICK_BASE  (TICK_BASE)
  ) u_dec (
    .addr_i     (m_addr_i),
    .hit_o      (dec_hit),
    .tick_hit_o (dec_tick),
    .miss_o     (dec_miss)
  );

  // Gated by reset so the master sees not-ready while reset is held.
  assign m_ready_o = rst_ni && (state_q == ST_IDLE);
  assign accept    = m_valid_i && m_ready_o;
  assign sel_ready = |(s_ready_i & sel_q);
  assign sel_ack   = |(s_ack_i & sel_q);
  assign to_expire = ((to_q + 8'd1) == TIMEOUT_CYC);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q[k]) sel_rdata = s_rdata_i[k*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    to_d    = to_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_tick || dec_miss) begin
            state_d = ST_RESP;
            err_d   = dec_miss;
            rdata_d = dec_miss ? 32'h0 : (m_addr_i[2] ? tick_q[63:32] : tick_q[31:0]);
          end else begin
            state_d = ST_REQ;
            sel_d   = dec_hit;
            to_d    = '0;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        to_d = to_q + 8'd1;
        // A completing response beats an expiring timeout in the same cycle.
        if (sel_ack && (state_q == ST_WAIT || sel_ready)) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = sel_rdata;
        end else if (to_expire) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (state_q == ST_REQ && sel_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A tick write replaces the increment for that cycle.
  always_comb begin
    tick_d = tick_q + 64'd1;
    if (accept && dec_tick && m_we_i) begin
      tick_d = tick_q;
      if (m_addr_i[2]) tick_d[63:32] = m_wdata_i;
      else             tick_d[31:0]  = m_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      tick_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      to_q    <= to_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      tick_q  <= tick_d;
      if (accept) begin
        addr_q  <= m_addr_i;
        wdata_q <= m_wdata_i;
        width_q <= m_width_i;
        we_q    <= m_we_i;
      end
    end
  end

  assign s_valid_o = (state_q == ST_REQ) ? sel_q : '0;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_width_o = width_q;
  assign s_we_o    = we_q;
  assign m_ack_o   = (state_q == ST_RESP);
  assign m_err_o   = err_q;
  assign m_rdata_o = rdata_q;

endmodule

// File: tb/tb_atom_dmem_xbar.sv
// Bench for atom_dmem_xbar: directed vector table, tick and reset sequences,
// then randomized traffic checked against a map/latency reference model.
module tb_atom_dmem_xbar;

  localparam int          NS    = 4;
  localparam logic [NS*32-1:0] BASE = {32'h4000_0000, 32'h1000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*32-1:0] MASK = {NS{32'hF000_0000}};
  localparam logic [31:0] TBASE = 32'hFFFF_FF00;
  localparam logic [31:0] MASKV = 32'hF000_0000;
  localparam int          TO    = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic m_valid, m_ready, m_we, m_ack, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_width;
  logic [NS-1:0] s_valid, s_ready, s_ack;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_width;
  logic        s_we;
  logic [NS*32-1:0] s_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] base_a [NS];

  always #5 clk = ~clk;

  atom_dmem_xbar #(
    .NUM_SLAVES (NS),
    .SLV_BASE   (BASE),
    .SLV_MASK   (MASK),
    .TICK_BASE  (TBASE),
    .TIMEOUT_CYC(8'(TO))
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_valid_i(m_valid), .m_ready_o(m_ready), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_width_i(m_width), .m_we_i(m_we), .m_ack_o(m_ack), .m_err_o(m_err), .m_rdata_o(m_rdata),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_width_o(s_width),
    .s_we_o(s_we), .s_ready_i(s_ready), .s_ack_i(s_ack), .s_rdata_i(s_rdata)
  );

  // Reference tick: counts every cycle, a bench-announced write replaces one word.
  logic [63:0] tick_m;
  logic        tk_wr, tk_hi;
  logic [31:0] tk_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tick_m <= '0;
    else if (tk_wr) begin
      if (tk_hi) tick_m[63:32] <= tk_data;
      else       tick_m[31:0]  <= tk_data;
    end else        tick_m <= tick_m + 64'd1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // -2 tick, -1 unmapped, else slave index
  function automatic int model_target(input logic [31:0] a);
    if ((a >> 3) == (TBASE >> 3)) return -2;
    for (int k = 0; k < NS; k++)
      if ((a & MASKV) == base_a[k]) return k;
    return -1;
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [2:0] w, input int rlat, input int alat,
                         input logic [31:0] srd, input int eslv, input int elat,
                         input logic eerr, input logic [31:0] erd, input logic chk_rd,
                         input logic etick);
    int lat, vcnt, hs_n, bad_sv, bad_rdy, sv_end;
    logic hs, got_err;
    logic [31:0] got_rd, erd_l;
    logic [NS-1:0] exp_sv;
    @(negedge clk);
    chk({nm, ".idle"}, {62'h0, m_ready, m_ack}, 64'h2);
    m_valid = 1'b1; m_addr = a; m_wdata = wd; m_we = we; m_width = w;
    tk_wr = (model_target(a) == -2) && we; tk_hi = a[2]; tk_data = wd;
    erd_l = erd;
    if (etick) erd_l = a[2] ? tick_m[63:32] : tick_m[31:0];
    @(negedge clk);
    m_valid = 1'b0; tk_wr = 1'b0;
    m_addr = $urandom; m_wdata = $urandom; m_we = 1'($urandom);
    chk({nm, ".saddr"}, 64'(s_addr), 64'(a));
    chk({nm, ".sreq"}, 64'({s_wdata, s_width, s_we}), 64'({wd, w, we}));
    lat = 0; vcnt = 0; hs = 1'b0; hs_n = 0; bad_sv = 0; bad_rdy = 0;
    got_err = 1'b0; got_rd = '0;
    sv_end = (rlat + 1 < TO) ? rlat + 1 : TO;
    for (int n = 1; n <= 40; n++) begin
      exp_sv = '0;
      if (eslv >= 0 && n <= sv_end) exp_sv[eslv] = 1'b1;
      if (s_valid !== exp_sv) bad_sv++;
      if (m_ready !== 1'b0) bad_rdy++;
      if (m_ack === 1'b1) begin
        lat = n; got_err = m_err; got_rd = m_rdata;
        break;
      end
      s_ready = NS'($urandom);
      s_ack   = NS'($urandom);
      for (int j = 0; j < NS; j++) s_rdata[j*32 +: 32] = $urandom;
      if (eslv >= 0) begin
        s_ready[eslv] = 1'b0;
        s_ack[eslv]   = 1'b0;
        if (!hs && s_valid[eslv] && vcnt >= rlat) begin
          s_ready[eslv] = 1'b1; hs = 1'b1; hs_n = n;
        end
        if (s_valid[eslv]) vcnt++;
        if (hs && n == hs_n + alat) begin
          s_ack[eslv] = 1'b1;
          s_rdata[eslv*32 +: 32] = srd;
        end
      end
      @(negedge clk);
    end
    s_ready = '0; s_ack = '0;
    chk({nm, ".svalid"}, 64'(bad_sv), 64'd0);
    chk({nm, ".busy"}, 64'(bad_rdy), 64'd0);
    chk({nm, ".lat"}, 64'(lat), 64'(elat));
    if (lat > 0) begin
      chk({nm, ".err"}, 64'(got_err), 64'(eerr));
      if (chk_rd) chk({nm, ".rdata"}, 64'(got_rd), 64'(erd_l));
    end
  endtask

  task automatic rand_txn(input int i);
    logic [31:0] a, wd, srd;
    logic we;
    logic [2:0] w;
    int t, rlat, alat, hc, ac;
    case ($urandom_range(0, 5))
      0: a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      1: a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
      2: a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
      3: a = 32'h3000_0000 | ($urandom & 32'h0FFF_FFFC);
      4: begin a = TBASE; a[2] = 1'($urandom); end
      default: a = $urandom;
    endcase
    wd = $urandom; srd = $urandom; we = 1'($urandom); w = 3'($urandom);
    rlat = $urandom_range(0, 5); alat = $urandom_range(0, 5);
    t = model_target(a);
    if (t == -2)
      run_txn($sformatf("rnd%0d", i), a, wd, we, w, rlat, alat, srd, -1, 1, 1'b0, 32'h0, !we, 1'b1);
    else if (t == -1)
      run_txn($sformatf("rnd%0d", i), a, wd, we, w, rlat, alat, srd, -1, 1, 1'b1, 32'h0, 1'b1, 1'b0);
    else begin
      hc = 1 + rlat; ac = hc + alat;
      if (ac > TO)
        run_txn($sformatf("rnd%0d", i), a, wd, we, w, rlat, alat, srd, t, TO + 1, 1'b1, 32'h0, 1'b1, 1'b0);
      else
        run_txn($sformatf("rnd%0d", i), a, wd, we, w, rlat, alat, srd, t, ac + 1, 1'b0, srd, 1'b1, 1'b0);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic [7:0]  rlat;
    logic [7:0]  alat;
    logic [31:0] srd;
    logic [3:0]  eslv;   // 4'hF: no slave
    logic [7:0]  elat;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int acks;
    base_a[0] = 32'h1000_0000; base_a[1] = 32'h2000_0000;
    base_a[2] = 32'h1000_0000; base_a[3] = 32'h4000_0000;
    tbl[0] = '{32'h2000_0010, 32'h0,      1'b0, 8'd0,  8'd0, 32'hDEAD_BEEF, 4'd1, 8'd2, 1'b0, 32'hDEAD_BEEF};
    tbl[1] = '{32'h9000_0000, 32'h1234,   1'b1, 8'd0,  8'd0, 32'h0,         4'hF, 8'd1, 1'b1, 32'h0};
    tbl[2] = '{32'h1000_0000, 32'h0,      1'b0, 8'd99, 8'd0, 32'h0,         4'd0, 8'd5, 1'b1, 32'h0};
    tbl[3] = '{32'h1000_0044, 32'h0,      1'b0, 8'd1,  8'd2, 32'hA5A5_0001, 4'd0, 8'd5, 1'b0, 32'hA5A5_0001};
    tbl[4] = '{32'h3000_0000, 32'h55,     1'b1, 8'd0,  8'd0, 32'h0,         4'hF, 8'd1, 1'b1, 32'h0};
    tbl[5] = '{32'h4000_0008, 32'hCAFE,   1'b1, 8'd0,  8'd1, 32'h0000_1111, 4'd3, 8'd3, 1'b0, 32'h0000_1111};
    tbl[6] = '{32'h2000_0000, 32'h0,      1'b0, 8'd3,  8'd0, 32'h7777_0000, 4'd1, 8'd5, 1'b0, 32'h7777_0000};
    tbl[7] = '{32'h4000_0100, 32'h0,      1'b0, 8'd2,  8'd2, 32'h1,         4'd3, 8'd5, 1'b1, 32'h0};

    rst_n = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_width = '0;
    s_ready = '0; s_ack = '0; s_rdata = '0; tk_wr = 1'b0; tk_hi = 1'b0; tk_data = '0;
    repeat (3) @(negedge clk);
    chk("rst.flags", 64'({m_ready, m_ack, m_err, s_valid, s_we, s_width}), 64'd0);
    chk("rst.rdata", 64'(m_rdata), 64'd0);
    chk("rst.sreq", {s_addr, s_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", 64'(m_ready), 64'd1);

    // Tick read right after reset, against the reference counter.
    run_txn("tick0", TBASE, 32'h0, 1'b0, 3'd0, 0, 0, 32'h0, -1, 1, 1'b0, 32'h0, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].wd, tbl[i].we, 3'd2,
              int'(tbl[i].rlat), int'(tbl[i].alat), tbl[i].srd,
              (tbl[i].eslv == 4'hF) ? -1 : int'(tbl[i].eslv),
              int'(tbl[i].elat), tbl[i].eerr, tbl[i].erd, 1'b1, 1'b0);

    // Carry from the low word into the high word.
    run_txn("twhi", TBASE + 32'd4, 32'h0,         1'b1, 3'd2, 0, 0, 32'h0, -1, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    run_txn("twlo", TBASE,         32'hFFFF_FFFF, 1'b1, 3'd2, 0, 0, 32'h0, -1, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    run_txn("tcarry", TBASE + 32'd4, 32'h0, 1'b0, 3'd2, 0, 0, 32'h0, -1, 1, 1'b0, 32'h1, 1'b1, 1'b0);
    // Written word holds during the write cycle, then counts on.
    run_txn("tw5", TBASE, 32'h5, 1'b1, 3'd0, 0, 0, 32'h0, -1, 1, 1'b0, 32'h0, 1'b0, 1'b0);
    run_txn("tnoinc", TBASE, 32'h0, 1'b0, 3'd0, 0, 0, 32'h0, -1, 1, 1'b0, 32'h6, 1'b1, 1'b0);
    run_txn("thi", TBASE + 32'd4, 32'h0, 1'b0, 3'd0, 0, 0, 32'h0, -1, 1, 1'b0, 32'h0, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) rand_txn(i);

    // Reset while a request is presented to slave 0.
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h1000_0020; m_we = 1'b0;
    @(negedge clk);
    m_valid = 1'b0;
    chk("rreq.sv", 64'(s_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1 chk("rreq.async", 64'({s_valid, m_ready, m_ack}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin @(negedge clk); if (m_ack) acks++; end
    chk("rreq.noack", 64'(acks), 64'd0);
    chk("rreq.ready", 64'(m_ready), 64'd1);

    // Reset while waiting for a response.
    m_valid = 1'b1; m_addr = 32'h1000_0030;
    @(negedge clk);
    m_valid = 1'b0; s_ready = 4'b0001;
    @(negedge clk);
    s_ready = '0;
    chk("rwait.state", 64'({s_valid, m_ready, m_ack}), 64'd0);
    #2 rst_n = 1'b0;
    #1 chk("rwait.async", 64'({s_valid, m_ready, m_ack}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin @(negedge clk); if (m_ack) acks++; end
    chk("rwait.noack", 64'(acks), 64'd0);
    chk("rwait.ready", 64'(m_ready), 64'd1);
    run_txn("post", tbl[0].a, 32'h0, 1'b0, 3'd2, 0, 0, 32'hDEAD_BEEF, 1, 2, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
